// File: rtl/sram_ctrl.sv
// MEM-stage bridge to a 16-bit async SRAM: one 32-bit access is split
// into a low and a high halfword phase, stalling the pipeline meanwhile.
module sram_ctrl #(
    parameter int ADDR_W   = 18,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rden,
    input  logic              mem_wren,
    input  logic [ADDR_W:0]   mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_be,
    output logic [31:0]       mem_rdata,
    output logic              sram_stall,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYC - 1);

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic [ADDR_W-2:0] waddr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              wr_q;
    logic [15:0]       rd_lo;
    logic [15:0]       rd_hi;
    logic              req;
    logic              last;
    logic              unused_addr_bits;

    assign req              = mem_rden | mem_wren;
    assign last             = (cnt == LAST);
    assign mem_rdata        = {rd_hi, rd_lo};
    assign unused_addr_bits = ^mem_addr[1:0];

    always_comb begin
        state_nx   = state;
        sram_stall = 1'b0;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_lb_n  = 1'b1;
        sram_ub_n  = 1'b1;
        sram_dq_oe = 1'b0;
        sram_dq_o  = 16'h0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    sram_stall = 1'b1;
                    if (mem_wren && mem_be == 4'b0000)
                        state_nx = DONE;
                    else if (mem_wren && mem_be[1:0] == 2'b00)
                        state_nx = HI;
                    else
                        state_nx = LO;
                end
            end
            LO: begin
                sram_stall = 1'b1;
                sram_ce_n  = 1'b0;
                sram_we_n  = ~wr_q;
                sram_oe_n  = wr_q;
                sram_dq_oe = wr_q;
                sram_lb_n  = wr_q & ~be_q[0];
                sram_ub_n  = wr_q & ~be_q[1];
                sram_dq_o  = wdata_q[15:0];
                if (last)
                    state_nx = (wr_q && be_q[3:2] == 2'b00) ? DONE : HI;
            end
            HI: begin
                sram_stall = 1'b1;
                sram_ce_n  = 1'b0;
                sram_we_n  = ~wr_q;
                sram_oe_n  = wr_q;
                sram_dq_oe = wr_q;
                sram_lb_n  = wr_q & ~be_q[2];
                sram_ub_n  = wr_q & ~be_q[3];
                sram_dq_o  = wdata_q[31:16];
                if (last)
                    state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // reset drops any in-flight access, so never hold the pipeline here
        if (rst)
            sram_stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            waddr_q   <= '0;
            wdata_q   <= 32'h0;
            be_q      <= 4'h0;
            wr_q      <= 1'b0;
            rd_lo     <= 16'h0;
            rd_hi     <= 16'h0;
            sram_addr <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req) begin
                waddr_q <= mem_addr[ADDR_W:2];
                wdata_q <= mem_wdata;
                be_q    <= mem_be;
                wr_q    <= mem_wren;
            end
            if (state == LO || state == HI)
                cnt <= last ? 4'd0 : cnt + 4'd1;
            if (state == LO && last && !wr_q)
                rd_lo <= sram_dq_i;
            if (state == HI && last && !wr_q)
                rd_hi <= sram_dq_i;
            // address is set on phase entry and held afterwards
            if (state_nx == LO && state != LO)
                sram_addr <= {mem_addr[ADDR_W:2], 1'b0};
            if (state_nx == HI && state != HI)
                sram_addr <= {(state == IDLE) ? mem_addr[ADDR_W:2] : waddr_q, 1'b1};
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural SRAM device plus a word-level memory
// model; directed cases pin the model, random traffic exercises the rest.
module tb_sram_ctrl;

    localparam int AW = 18;
    localparam int W  = 2;

    typedef struct packed {
        logic [AW-1:0] a;
        logic          we_n;
        logic          oe_n;
        logic          lb_n;
        logic          ub_n;
        logic [15:0]   d;
    } bus_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_rden;
    logic          mem_wren;
    logic [AW:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata;
    logic          sram_stall;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_o;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_i;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic          sram_lb_n;
    logic          sram_ub_n;

    logic [15:0] dev [256];
    logic [31:0] mdl [128];
    bus_t        busq [$];
    int          vec = 0;
    int          mis = 0;
    bit          mon_en = 1'b0;

    sram_ctrl #(.ADDR_W(AW), .WAIT_CYC(W)) dut (
        .clk(clk), .rst(rst),
        .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .sram_stall(sram_stall),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n),
        .sram_ub_n(sram_ub_n)
    );

    always #5 clk = ~clk;

    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? dev[sram_addr[7:0]] : 16'h0;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) dev[sram_addr[7:0]][7:0]  <= sram_dq_o[7:0];
            if (!sram_ub_n) dev[sram_addr[7:0]][15:8] <= sram_dq_o[15:8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) chk("stall_in_rst", 32'(sram_stall), 32'd0);
            chk("we_oe_excl", 32'(!sram_we_n && !sram_oe_n), 32'd0);
            chk("dq_oe", 32'(sram_dq_oe), 32'(!sram_ce_n && !sram_we_n));
            if (sram_ce_n)
                chk("idle_pins", 32'({sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'hF);
            else
                busq.push_back('{sram_addr, sram_we_n, sram_oe_n,
                                 sram_lb_n, sram_ub_n, sram_dq_o});
        end
    end

    task automatic idle(input int n);
        @(posedge clk); #1;
        mem_rden = 1'b0;
        mem_wren = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic do_access(input bit wr, input int word, input logic [31:0] wd,
                             input logic [3:0] be, output int nst, output logic [31:0] rd);
        bus_t exq [$];
        int   exp_st;
        bit   lo_on;
        bit   hi_on;
        bit   done;
        @(posedge clk); #1;
        busq.delete();
        mem_rden  = !wr;
        mem_wren  = wr;
        mem_addr  = 19'(word * 4 + $urandom_range(0, 3));
        mem_wdata = wd;
        mem_be    = be;
        lo_on = !wr || (be[1:0] != 2'b00);
        hi_on = !wr || (be[3:2] != 2'b00);
        exp_st = 1 + W * (int'(lo_on) + int'(hi_on));
        nst  = 0;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (sram_stall) nst++;
            else done = 1'b1;
        end
        if (!done) chk("stall_timeout", 32'd1, 32'd0);
        #1;
        chk("stall_cycles", 32'(nst), 32'(exp_st));
        chk("done_ce_n", 32'(sram_ce_n), 32'd1);
        rd = mem_rdata;
        if (!wr) chk("rdata", mem_rdata, mdl[word]);
        for (int h = 0; h < 2; h++) begin
            if ((h == 0) ? lo_on : hi_on) begin
                for (int c = 0; c < W; c++)
                    exq.push_back('{18'(word * 2 + h), !wr, wr,
                                    wr ? !be[2*h] : 1'b0,
                                    wr ? !be[2*h+1] : 1'b0,
                                    (h == 0) ? wd[15:0] : wd[31:16]});
            end
        end
        chk("bus_len", 32'(busq.size()), 32'(exq.size()));
        for (int i = 0; i < exq.size() && i < busq.size(); i++) begin
            chk("bus_addr", 32'(busq[i].a), 32'(exq[i].a));
            chk("bus_ctl", 32'({busq[i].we_n, busq[i].oe_n, busq[i].lb_n, busq[i].ub_n}),
                32'({exq[i].we_n, exq[i].oe_n, exq[i].lb_n, exq[i].ub_n}));
            if (wr) chk("bus_dq", 32'(busq[i].d), 32'(exq[i].d));
        end
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mdl[word][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    initial begin
        int          nst;
        logic [31:0] rd;
        rst = 1'b1;
        mem_rden = 1'b1;
        mem_wren = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        mem_be = '0;
        for (int i = 0; i < 128; i++) begin
            mdl[i] = $urandom;
            dev[2*i]   = mdl[i][15:0];
            dev[2*i+1] = mdl[i][31:16];
        end
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_rden = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", 32'(sram_stall), 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_pins", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'hE);

        dev[0] = 16'h5678; dev[1] = 16'h1234; mdl[0] = 32'h1234_5678;
        do_access(1'b0, 0, 32'h0, 4'h0, nst, rd);
        chk("lit_load_stall", 32'(nst), 32'd5);
        chk("lit_load_rdata", rd, 32'h1234_5678);
        chk("lit_load_oe_cycles", 32'(busq.size()), 32'd4);

        do_access(1'b1, 2, 32'hCAFE_F00D, 4'hF, nst, rd);
        chk("lit_st_stall", 32'(nst), 32'd5);
        chk("lit_st_hw4", 32'(dev[4]), 32'h0000_F00D);
        chk("lit_st_hw5", 32'(dev[5]), 32'h0000_CAFE);
        do_access(1'b0, 2, 32'h0, 4'h0, nst, rd);
        chk("lit_readback", rd, 32'hCAFE_F00D);

        do_access(1'b1, 3, 32'h00AB_0000, 4'b0100, nst, rd);
        chk("lit_hi_only_stall", 32'(nst), 32'd3);
        chk("lit_hi_only_addr", 32'(busq[0].a), 32'd7);
        chk("lit_hi_only_lanes", 32'({busq[0].lb_n, busq[0].ub_n}), 32'b01);

        do_access(1'b0, 5, 32'h0, 4'h0, nst, rd);
        chk("lit_b2b_ld", 32'(nst), 32'd5);
        do_access(1'b1, 6, 32'h1357_9BDF, 4'hF, nst, rd);
        chk("lit_b2b_st", 32'(nst), 32'd5);

        do_access(1'b1, 9, 32'hFFFF_FFFF, 4'b0000, nst, rd);
        chk("lit_be0_stall", 32'(nst), 32'd1);
        chk("lit_be0_bus", 32'(busq.size()), 32'd0);

        dev[32] = 16'h1111; dev[33] = 16'h2222; mdl[16] = 32'h2222_1111;
        @(posedge clk); #1;
        mem_wren = 1'b1; mem_rden = 1'b0;
        mem_addr = 19'h40; mem_wdata = 32'hA5A5_3C3C; mem_be = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_wren = 1'b0;
        @(negedge clk);
        chk("abort_stall", 32'(sram_stall), 32'd0);
        chk("abort_pins", 32'({sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe}), 32'hE);
        mdl[16][15:0] = 16'h3C3C;
        do_access(1'b0, 16, 32'h0, 4'h0, nst, rd);
        chk("lit_abort_word", rd, 32'h2222_3C3C);

        for (int t = 0; t < 300; t++) begin
            bit          wr;
            logic [3:0]  be;
            wr = 1'($urandom_range(0, 1));
            be = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            do_access(wr, $urandom_range(0, 127), $urandom, be, nst, rd);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 2));
        end
        idle(2);
        for (int i = 0; i < 128; i++) begin
            chk("final_lo", 32'(dev[2*i]), 32'(mdl[i][15:0]));
            chk("final_hi", 32'(dev[2*i+1]), 32'(mdl[i][31:16]));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
